// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and default widths for the writeback arbiter
//
// Purpose: holds the default width constants and the buffered-result entry type
// {addr, data} used by the writeback arbiter and its per-source FIFOs.
// Ports: none (package).
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_SOURCES    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result FIFO holding {addr, data} entries
//
// Purpose: small synchronous FIFO buffering one producer's results until the
// arbiter grants them. Head entry is visible combinationally.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear; blocks push and pop that cycle
//   push, push_addr/data  write one entry (ignored when full)
//   pop                   remove head entry (ignored when empty)
//   full, empty           occupancy flags
//   head_addr, head_data  oldest entry
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin merge of result producers onto two register-file write ports
//
// Purpose: each producer pushes {addr, data} results into its own FIFO; every
// cycle the two oldest-in-rotation non-empty FIFOs are granted and their heads
// are registered onto write port 1 (grant A) and write port 2 (grant B).
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   flush                                drop all buffered results
//   src_valid/src_addr/src_data/src_ready  per-source result handshake
//   write_En/Addr/Data                   write port 1 (grant A)
//   write_En_2/Addr_2/Data_2             write port 2 (grant B, later in rotation)
//   busy                                 any FIFO holds an entry
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SOURCES    = DEF_SOURCES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [SOURCES-1:0]                  src_valid,
  input  logic [SOURCES-1:0][ADDR_WIDTH-1:0]  src_addr,
  input  logic [SOURCES-1:0][DATA_WIDTH-1:0]  src_data,
  output logic [SOURCES-1:0]                  src_ready,
  output logic                                write_En,
  output logic [ADDR_WIDTH-1:0]               write_Addr,
  output logic [DATA_WIDTH-1:0]               write_Data,
  output logic                                write_En_2,
  output logic [ADDR_WIDTH-1:0]               write_Addr_2,
  output logic [DATA_WIDTH-1:0]               write_Data_2,
  output logic                                busy
);

  localparam int PW = $clog2(SOURCES);

  logic [SOURCES-1:0]    full;
  logic [SOURCES-1:0]    empty;
  logic [SOURCES-1:0]    push;
  logic [SOURCES-1:0]    pop;
  logic [ADDR_WIDTH-1:0] head_addr [SOURCES];
  logic [DATA_WIDTH-1:0] head_data [SOURCES];

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] ga_idx;
  logic [PW-1:0] gb_idx;
  logic [PW-1:0] last_idx;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic          ga_v;
  logic          gb_v;
  logic          a_wr;
  logic          b_wr;

  // Readiness depends only on the registered full flag, so a same-cycle pop
  // of a full FIFO cannot open it for a push.
  assign src_ready = ~full & {SOURCES{~flush}};
  assign push      = src_valid & src_ready;
  assign busy      = ~&empty;

  for (genvar i = 0; i < SOURCES; i++) begin : g_fifo
    wb_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push[i]),
      .push_addr (src_addr[i]),
      .push_data (src_data[i]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head_addr (head_addr[i]),
      .head_data (head_data[i])
    );
  end

  // Circular scan from rr_ptr: first non-empty source is A, second is B.
  always_comb begin
    ga_v     = 1'b0;
    gb_v     = 1'b0;
    ga_idx   = '0;
    gb_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < SOURCES; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW + 1)'(k);
      if (scan_sum >= (PW + 1)'(SOURCES)) scan_sum = scan_sum - (PW + 1)'(SOURCES);
      scan_idx = scan_sum[PW-1:0];
      if (!empty[scan_idx]) begin
        if (!ga_v) begin
          ga_v   = 1'b1;
          ga_idx = scan_idx;
        end else if (!gb_v) begin
          gb_v   = 1'b1;
          gb_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (!flush) begin
      if (ga_v) pop[ga_idx] = 1'b1;
      if (gb_v) pop[gb_idx] = 1'b1;
    end
  end

  // Address 0 is a discard target: the grant is consumed but nothing is written.
  assign a_wr     = ga_v && (head_addr[ga_idx] != '0);
  assign b_wr     = gb_v && (head_addr[gb_idx] != '0);
  assign last_idx = gb_v ? gb_idx : ga_idx;
  assign rr_next  = (last_idx == PW'(SOURCES - 1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      write_En     <= 1'b0;
      write_Addr   <= '0;
      write_Data   <= '0;
      write_En_2   <= 1'b0;
      write_Addr_2 <= '0;
      write_Data_2 <= '0;
    end else if (flush) begin
      write_En   <= 1'b0;
      write_En_2 <= 1'b0;
    end else begin
      write_En   <= a_wr;
      write_En_2 <= b_wr;
      // Address/data only move when the port actually writes.
      if (a_wr) begin
        write_Addr <= head_addr[ga_idx];
        write_Data <= head_data[ga_idx];
      end
      if (b_wr) begin
        write_Addr_2 <= head_addr[gb_idx];
        write_Data_2 <= head_data[gb_idx];
      end
      if (ga_v) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [NS-1:0]         src_valid;
  logic [NS-1:0][AW-1:0] src_addr;
  logic [NS-1:0][DW-1:0] src_data;
  logic [NS-1:0]         src_ready;
  logic                  write_En;
  logic [AW-1:0]         write_Addr;
  logic [DW-1:0]         write_Data;
  logic                  write_En_2;
  logic [AW-1:0]         write_Addr_2;
  logic [DW-1:0]         write_Data_2;
  logic                  busy;

  regfile_wb_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SOURCES    (NS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .write_En     (write_En),
    .write_Addr   (write_Addr),
    .write_Data   (write_Data),
    .write_En_2   (write_En_2),
    .write_Addr_2 (write_Addr_2),
    .write_Data_2 (write_Data_2),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per source, a rotation pointer, expected ports.
  wb_entry_t     q [NS][$];
  int            rr;
  logic          m_e1, m_e2;
  logic [AW-1:0] m_a1, m_a2;
  logic [DW-1:0] m_d1, m_d2;

  typedef struct packed {
    logic [NS-1:0]         v;
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    logic                  e1;
    logic [AW-1:0]         a1;
    logic [DW-1:0]         d1;
    logic                  e2;
    logic [AW-1:0]         a2;
    logic [DW-1:0]         d2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, "_en1"},   write_En,     m_e1);
    chk({tag, "_addr1"}, write_Addr,   m_a1);
    chk({tag, "_data1"}, write_Data,   m_d1);
    chk({tag, "_en2"},   write_En_2,   m_e2);
    chk({tag, "_addr2"}, write_Addr_2, m_a2);
    chk({tag, "_data2"}, write_Data_2, m_d2);
  endtask

  task automatic do_reset();
    flush     = 1'b0;
    src_valid = '0;
    rst_n     = 1'b0;
    #1;
    for (int i = 0; i < NS; i++) q[i].delete();
    rr   = 0;
    m_e1 = 0; m_a1 = '0; m_d1 = '0;
    m_e2 = 0; m_a2 = '0; m_d2 = '0;
    chk_ports("reset");
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", src_ready, {NS{1'b1}});
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check ready/busy, advance model, check ports after the edge.
  task automatic step(input logic fl, input logic [NS-1:0] v, input logic [NS-1:0][AW-1:0] a,
                      input logic [NS-1:0][DW-1:0] d, output logic [NS-1:0] acc);
    logic [NS-1:0] rdy;
    logic          any;
    int            ga, gb, last, idx;
    wb_entry_t     e;
    flush     = fl;
    src_valid = v;
    src_addr  = a;
    src_data  = d;
    #1;
    any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = !fl && (q[i].size() < DEPTH);
      if (q[i].size() != 0) any = 1'b1;
    end
    chk("src_ready", src_ready, rdy);
    chk("busy", busy, any);
    acc = v & rdy;
    if (fl) begin
      for (int i = 0; i < NS; i++) q[i].delete();
      m_e1 = 0;
      m_e2 = 0;
    end else begin
      ga = -1;
      gb = -1;
      for (int k = 0; k < NS; k++) begin
        idx = (rr + k) % NS;
        if (q[idx].size() > 0) begin
          if (ga < 0) ga = idx;
          else if (gb < 0) gb = idx;
        end
      end
      m_e1 = 0;
      m_e2 = 0;
      if (ga >= 0) begin
        e = q[ga].pop_front();
        if (e.addr != 0) begin m_e1 = 1; m_a1 = e.addr; m_d1 = e.data; end
      end
      if (gb >= 0) begin
        e = q[gb].pop_front();
        if (e.addr != 0) begin m_e2 = 1; m_a2 = e.addr; m_d2 = e.data; end
      end
      last = (gb >= 0) ? gb : ga;
      if (last >= 0) rr = (last + 1) % NS;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          e.addr = a[i];
          e.data = d[i];
          q[i].push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    chk_ports("port");
  endtask

  initial begin
    logic [NS-1:0]         acc;
    logic [NS-1:0]         v;
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    logic                  saw_full;
    logic [DW-1:0]         rf_val;
    int                    sent, cyc;
    int                    got [$];

    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;

    // Single-cycle pushes from an empty, freshly reset arbiter (rr_ptr = 0).
    vecs[0] = {4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'h0, 32'hAA, 32'h0, 32'h0},
               1'b1, 6'd5, 32'hAA, 1'b0, 6'd0, 32'h0};
    vecs[1] = {4'b0011, {6'd0, 6'd0, 6'd4, 6'd3}, {32'h0, 32'h0, 32'h22, 32'h11},
               1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22};
    vecs[2] = {4'b0011, {6'd0, 6'd0, 6'd7, 6'd7}, {32'h0, 32'h0, 32'h66, 32'h55},
               1'b1, 6'd7, 32'h55, 1'b1, 6'd7, 32'h66};
    vecs[3] = {4'b1000, {6'd0, 6'd0, 6'd0, 6'd0}, {32'hDEAD, 32'h0, 32'h0, 32'h0},
               1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0};
    vecs[4] = {4'b1010, {6'd10, 6'd0, 6'd9, 6'd0}, {32'h2, 32'h0, 32'h1, 32'h0},
               1'b1, 6'd9, 32'h1, 1'b1, 6'd10, 32'h2};
    vecs[5] = {4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, {32'h0, 32'hC, 32'hB, 32'hA},
               1'b1, 6'd1, 32'hA, 1'b1, 6'd2, 32'hB};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      step(1'b0, vecs[i].v, vecs[i].a, vecs[i].d, acc);
      step(1'b0, '0, '0, '0, acc);
      chk("vec_en1",   write_En,     vecs[i].e1);
      chk("vec_addr1", write_Addr,   vecs[i].a1);
      chk("vec_data1", write_Data,   vecs[i].d1);
      chk("vec_en2",   write_En_2,   vecs[i].e2);
      chk("vec_addr2", write_Addr_2, vecs[i].a2);
      chk("vec_data2", write_Data_2, vecs[i].d2);
      if (i == 2) begin
        rf_val = write_Data;
        if (write_En_2 && write_Addr_2 == write_Addr) rf_val = write_Data_2;
        chk("same_addr_rf", rf_val, 32'h66);
      end
      if (i == 3) chk("addr0_busy", busy, 1'b0);
    end

    // Rotation pointer lands past the last grant: next round starts at source 2.
    do_reset();
    step(1'b0, 4'b0011, {6'd0, 6'd0, 6'd4, 6'd3}, {32'h0, 32'h0, 32'h22, 32'h11}, acc);
    step(1'b0, 4'b0101, {6'd0, 6'd13, 6'd0, 6'd12}, {32'h0, 32'hC2, 32'h0, 32'hC0}, acc);
    step(1'b0, '0, '0, '0, acc);
    chk("rr_port1_addr", write_Addr, 6'd13);
    chk("rr_port2_addr", write_Addr_2, 6'd12);

    // Backpressure: all sources stream, source 0 sends 10 tagged values.
    do_reset();
    sent     = 0;
    cyc      = 0;
    saw_full = 1'b0;
    got.delete();
    while (cyc < 100 && (sent < 10 || busy)) begin
      a = {6'd13, 6'd12, 6'd11, 6'(sent + 1)};
      d = {32'h0B000003, 32'h0B000002, 32'h0B000001, 32'h0A000000 | sent};
      v = (sent < 10) ? 4'b1111 : 4'b0000;
      step(1'b0, v, a, d, acc);
      if (v[0] && !acc[0]) saw_full = 1'b1;
      if (acc[0]) sent++;
      if (write_En && write_Data[31:24] == 8'h0A) got.push_back(int'(write_Data[7:0]));
      if (write_En_2 && write_Data_2[31:24] == 8'h0A) got.push_back(int'(write_Data_2[7:0]));
      cyc++;
    end
    chk("bp_saw_full", saw_full, 1'b1);
    chk("bp_drained", busy, 1'b0);
    chk("bp_count", got.size(), 10);
    for (int j = 0; j < got.size() && j < 10; j++) chk("bp_order", got[j], j);

    // Flush with three FIFOs occupied.
    do_reset();
    for (int r = 0; r < 3; r++)
      step(1'b0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, {32'h0, 32'h33, 32'h22, 32'h11}, acc);
    step(1'b1, 4'b1111, {6'd9, 6'd9, 6'd9, 6'd9}, {32'h9, 32'h9, 32'h9, 32'h9}, acc);
    chk("flush_busy", busy, 1'b0);
    chk("flush_en1", write_En, 1'b0);
    chk("flush_en2", write_En_2, 1'b0);
    step(1'b0, '0, '0, '0, acc);

    // Reset mid-operation with three FIFOs occupied.
    for (int r = 0; r < 3; r++)
      step(1'b0, 4'b1110, {6'd4, 6'd3, 6'd2, 6'd0}, {32'h44, 32'h33, 32'h22, 32'h0}, acc);
    do_reset();
    step(1'b0, '0, '0, '0, acc);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      v = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        a[i] = AW'($urandom_range(0, 7));
        d[i] = $urandom;
      end
      step($urandom_range(0, 49) == 0, v, a, d, acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
